// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and the read-credit helper for the FIFO-to-stream read adapter.
package fifo_rd_stream_pkg;

  localparam string FWFT_TRUE  = "TRUE";
  localparam string FWFT_FALSE = "FALSE";

  typedef logic [1:0] bufcnt_t;

  // Words already owned (buffered plus in flight, less the one leaving now) must leave a free slot.
  function automatic logic creditOk(input bufcnt_t cnt, input logic inflight, input logic pop);
    logic [2:0] owned;
    owned = {1'b0, cnt} + {2'b00, inflight};
    return owned < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream; master is the adapter side.
interface fifo_rd_stream_if #(parameter int DATA_W = 32);

  logic              f_empty;
  logic              f_r_req;
  logic [DATA_W-1:0] f_r_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  f_empty, f_r_data, m_ready,
    output f_r_req, m_valid, m_data
  );

  modport slave (
    output f_empty, f_r_data, m_ready,
    input  f_r_req, m_valid, m_data
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer: entry A is the registered stream head, entry B the skid slot behind it.
module stream_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_data,
  output bufcnt_t           buf_cnt
);

  logic              a_valid_q;
  logic              b_valid_q;
  logic [DATA_W-1:0] a_data_q;
  logic [DATA_W-1:0] b_data_q;

  // A push alongside a pop with both entries full is legal: B advances to A and the new word refills B.
  always_ff @(posedge clk) begin
    if (!nrst || clr) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else if (pop) begin
      if (b_valid_q) begin
        a_data_q  <= b_data_q;
        a_valid_q <= 1'b1;
        b_valid_q <= push;
        if (push) b_data_q <= push_data;
      end else begin
        a_valid_q <= push;
        if (push) a_data_q <= push_data;
      end
    end else if (push) begin
      if (!a_valid_q) begin
        a_valid_q <= 1'b1;
        a_data_q  <= push_data;
      end else begin
        b_valid_q <= 1'b1;
        b_data_q  <= push_data;
      end
    end
  end

  assign a_valid = a_valid_q;
  assign a_data  = a_data_q;
  assign buf_cnt = {a_valid_q & b_valid_q, a_valid_q ^ b_valid_q};

  overflowNever: assert property (@(posedge clk) disable iff (!nrst || clr)
                                  !(push && !pop && buf_cnt == 2'd2));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a single-clock FIFO (FWFT or registered read) into a valid/ready stream without losing words.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter string FWFT_MODE = FWFT_TRUE,
  parameter int    DATA_W    = 32,
  parameter int    CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 flush,
  fifo_rd_stream_if.master     bus,
  output bufcnt_t              buf_cnt,
  output logic [CNT_W-1:0]     words_out
);

  localparam bit IsFwft = (FWFT_MODE == FWFT_TRUE);

  logic             pop;
  logic             push;
  logic             inflight_q;
  logic             inflight_d;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] words_d;

  assign pop = bus.m_valid & bus.m_ready;

  assign bus.f_r_req = nrst & ~flush & ~bus.f_empty & creditOk(buf_cnt, inflight_q, pop);

  // A registered-read word lands one cycle late; a flush in that cycle drops it.
  assign push       = IsFwft ? bus.f_r_req : (inflight_q & ~flush);
  assign inflight_d = IsFwft ? 1'b0 : bus.f_r_req;
  assign words_d    = pop ? words_q + CNT_W'(1) : words_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      inflight_q <= 1'b0;
      words_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      words_q    <= words_d;
    end
  end

  stream_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (flush),
    .push      (push),
    .push_data (bus.f_r_data),
    .pop       (pop),
    .a_valid   (bus.m_valid),
    .a_data    (bus.m_data),
    .buf_cnt   (buf_cnt)
  );

  assign words_out = words_q;

endmodule
